// File: rtl/tdc_pkg.sv
// Shared types for the tinydumbcpu job controller.
package tdc_pkg;

    localparam int unsigned OPCODE_W = 3;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StClear,
        StRun,
        StDone
    } ctrl_state_t;

    typedef enum logic [1:0] {
        ExitNone    = 2'd0,
        ExitOk      = 2'd1,
        ExitTimeout = 2'd2,
        ExitAborted = 2'd3
    } exit_status_t;

endpackage

// File: rtl/ctrl_step_counter.sv
// Saturating RUN-cycle counter with a step-limit compare (limit 0 = unlimited).
module ctrl_step_counter #(
    parameter int unsigned STEP_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              enable,
    input  logic [STEP_W-1:0] limit,
    output logic              timeout
);

    logic [STEP_W-1:0] count_q, count_d;

    // Next count: clear wins, otherwise count up and stick at all-ones.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != {STEP_W{1'b1}})) begin
            count_d = count_q + STEP_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout = (limit != '0) && (count_q == limit);

endmodule

// File: rtl/core_run_controller.sv
// Job sequencer: loads program ROM, zero-fills tape, runs the core and reports exit status.
module core_run_controller
    import tdc_pkg::*;
#(
    parameter int unsigned PC_W     = 16,
    parameter int unsigned TAPE_AW  = 16,
    parameter int unsigned STEP_W   = 32,
    parameter bit          CLEAR_EN = 1'b1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                host_start,
    input  logic                host_abort,
    input  logic [PC_W-1:0]     host_prog_len,
    input  logic [STEP_W-1:0]   step_limit,
    input  logic                host_op_valid,
    input  logic [OPCODE_W-1:0] host_op_data,
    output logic                host_op_ready,
    output logic                pmem_we,
    output logic [PC_W-1:0]     pmem_addr,
    output logic [OPCODE_W-1:0] pmem_data_write,
    output logic                tape_clr_we,
    output logic [TAPE_AW-1:0]  tape_clr_addr,
    output logic                tape_owner,
    output logic                core_reset_n,
    input  logic [PC_W-1:0]     core_pc,
    output logic                busy,
    output logic                done,
    output logic [1:0]          exit_status
);

    localparam ctrl_state_t AfterLoad = ctrl_state_t'(CLEAR_EN ? StClear : StRun);

    ctrl_state_t         state_q, state_d;
    exit_status_t        status_q, status_d;
    logic [PC_W-1:0]     len_q, len_d;
    logic [STEP_W-1:0]   limit_q, limit_d;
    logic [PC_W-1:0]     op_idx_q, op_idx_d;
    logic                pmem_we_q, pmem_we_d;
    logic [PC_W-1:0]     pmem_addr_q, pmem_addr_d;
    logic [OPCODE_W-1:0] pmem_data_q, pmem_data_d;
    logic [TAPE_AW-1:0]  clr_addr_q, clr_addr_d;
    logic                ready_q, ready_d;
    logic                clr_we_q, clr_we_d;
    logic                owner_q, owner_d;
    logic                core_rst_n_q, core_rst_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                run_timeout;

    ctrl_step_counter #(
        .STEP_W (STEP_W)
    ) u_step_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (state_q != StRun),
        .enable  (state_q == StRun),
        .limit   (limit_q),
        .timeout (run_timeout)
    );

    // Next-state, job bookkeeping and registered-output decode.
    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        len_d       = len_q;
        limit_d     = limit_q;
        op_idx_d    = op_idx_q;
        pmem_we_d   = 1'b0;
        pmem_addr_d = pmem_addr_q;
        pmem_data_d = pmem_data_q;
        clr_addr_d  = '0;

        unique case (state_q)
            StIdle, StDone: begin
                if (host_start) begin
                    len_d    = host_prog_len;
                    limit_d  = step_limit;
                    op_idx_d = '0;
                    status_d = ExitNone;
                    state_d  = (host_prog_len == '0) ? AfterLoad : StLoad;
                end
            end
            StLoad: begin
                if (host_abort) begin
                    state_d  = StDone;
                    status_d = ExitAborted;
                end else if (host_op_valid) begin
                    // Ready is always high in LOAD, so valid alone is a handshake.
                    pmem_we_d   = 1'b1;
                    pmem_addr_d = op_idx_q;
                    pmem_data_d = host_op_data;
                    op_idx_d    = op_idx_q + PC_W'(1);
                    if (op_idx_q == len_q - PC_W'(1)) begin
                        state_d = AfterLoad;
                    end
                end
            end
            StClear: begin
                clr_addr_d = clr_addr_q + TAPE_AW'(1);
                if (host_abort) begin
                    state_d  = StDone;
                    status_d = ExitAborted;
                end else if (clr_addr_q == {TAPE_AW{1'b1}}) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (host_abort) begin
                    state_d  = StDone;
                    status_d = ExitAborted;
                end else if (run_timeout) begin
                    state_d  = StDone;
                    status_d = ExitTimeout;
                end else if (core_pc >= len_q) begin
                    state_d  = StDone;
                    status_d = ExitOk;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        ready_d      = (state_d == StLoad);
        clr_we_d     = (state_d == StClear);
        core_rst_n_d = (state_d == StRun);
        owner_d      = (state_d == StRun) || (state_d == StDone);
        busy_d       = (state_d == StLoad) || (state_d == StClear) || (state_d == StRun);
        done_d       = (state_d == StDone);
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            status_q     <= ExitNone;
            len_q        <= '0;
            limit_q      <= '0;
            op_idx_q     <= '0;
            pmem_we_q    <= 1'b0;
            pmem_addr_q  <= '0;
            pmem_data_q  <= '0;
            clr_addr_q   <= '0;
            ready_q      <= 1'b0;
            clr_we_q     <= 1'b0;
            owner_q      <= 1'b0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            len_q        <= len_d;
            limit_q      <= limit_d;
            op_idx_q     <= op_idx_d;
            pmem_we_q    <= pmem_we_d;
            pmem_addr_q  <= pmem_addr_d;
            pmem_data_q  <= pmem_data_d;
            clr_addr_q   <= clr_addr_d;
            ready_q      <= ready_d;
            clr_we_q     <= clr_we_d;
            owner_q      <= owner_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign host_op_ready   = ready_q;
    assign pmem_we         = pmem_we_q;
    assign pmem_addr       = pmem_addr_q;
    assign pmem_data_write = pmem_data_q;
    assign tape_clr_we     = clr_we_q;
    assign tape_clr_addr   = clr_addr_q;
    assign tape_owner      = owner_q;
    assign core_reset_n    = core_rst_n_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign exit_status     = status_q;

endmodule

// File: tb/tb_core_run_controller.sv
// Bench: dut_a uses full-size tape with clearing, dut_b skips clearing for fast job runs.
module tb_core_run_controller;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n, start_a, start_b, host_abort, host_op_valid;
    logic [15:0] host_prog_len, core_pc;
    logic [31:0] step_limit;
    logic [2:0]  host_op_data;

    logic        ready_a, we_a, clr_we_a, owner_a, crst_a, busy_a, done_a;
    logic [15:0] addr_a, clr_addr_a;
    logic [2:0]  data_a;
    logic [1:0]  status_a;

    logic        ready_b, we_b, clr_we_b, owner_b, crst_b, busy_b, done_b;
    logic [15:0] addr_b;
    logic [2:0]  clr_addr_b;
    logic [2:0]  data_b;
    logic [1:0]  status_b;

    int total = 0;
    int bad   = 0;

    core_run_controller dut_a (
        .clock(clock), .reset_n(reset_n), .host_start(start_a), .host_abort(host_abort),
        .host_prog_len(host_prog_len), .step_limit(step_limit),
        .host_op_valid(host_op_valid), .host_op_data(host_op_data), .host_op_ready(ready_a),
        .pmem_we(we_a), .pmem_addr(addr_a), .pmem_data_write(data_a),
        .tape_clr_we(clr_we_a), .tape_clr_addr(clr_addr_a), .tape_owner(owner_a),
        .core_reset_n(crst_a), .core_pc(core_pc), .busy(busy_a), .done(done_a),
        .exit_status(status_a)
    );

    core_run_controller #(
        .TAPE_AW(3), .CLEAR_EN(1'b0)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .host_start(start_b), .host_abort(host_abort),
        .host_prog_len(host_prog_len), .step_limit(step_limit),
        .host_op_valid(host_op_valid), .host_op_data(host_op_data), .host_op_ready(ready_b),
        .pmem_we(we_b), .pmem_addr(addr_b), .pmem_data_write(data_b),
        .tape_clr_we(clr_we_b), .tape_clr_addr(clr_addr_b), .tape_owner(owner_b),
        .core_reset_n(crst_b), .core_pc(core_pc), .busy(busy_b), .done(done_b),
        .exit_status(status_b)
    );

    typedef struct {
        int len;
        int lim;
        int stride;
        int abort_at;
        int exp_status;
        int exp_cycles;
    } job_t;

    job_t tbl[7];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference: the run stops at the first RUN cycle index hitting abort, limit or end,
    // with ties resolved abort > timeout > end. core_pc is k/stride, so end is len*stride.
    function automatic void predict(input int len, input int lim, input int stride,
                                    input int abort_at, output int st, output int cyc);
        int ke, kt, ka, ks;
        ke = len * stride;
        kt = (lim == 0) ? 32'h3fff_ffff : lim;
        ka = (abort_at < 0) ? 32'h3fff_ffff : abort_at;
        ks = ke;
        if (kt < ks) ks = kt;
        if (ka < ks) ks = ka;
        st  = (ka == ks) ? 3 : ((kt == ks) ? 2 : 1);
        cyc = ks + 1;
    endfunction

    // One job on dut_b: random ops with random valid gaps, then a supervised run.
    task automatic run_job_b(input int len, input int lim, input int stride, input int abort_at,
                             input int exp_status, input int exp_cycles);
        logic [2:0] ops[$];
        logic [2:0] pend_op;
        logic       pend;
        int         acc, pend_addr, guard;
        for (int i = 0; i < len; i++) ops.push_back(3'($urandom_range(0, 7)));
        host_prog_len = 16'(len);
        step_limit    = 32'(lim);
        core_pc       = '0;
        start_b       = 1'b1;
        tick();
        start_b   = 1'b0;
        acc       = 0;
        pend      = 1'b0;
        pend_op   = '0;
        pend_addr = 0;
        guard     = 0;
        while (acc < len && guard < 1000) begin
            check("load_ready", ready_b, 1'b1);
            check("load_busy", busy_b, 1'b1);
            check("load_core_rst", crst_b, 1'b0);
            check("load_we", we_b, pend);
            if (pend) begin
                check("load_addr", addr_b, pend_addr);
                check("load_data", data_b, pend_op);
            end
            host_op_valid = ($urandom_range(0, 2) != 0);
            host_op_data  = host_op_valid ? ops[acc] : 3'($urandom_range(0, 7));
            pend          = host_op_valid;
            if (host_op_valid) begin
                pend_op   = ops[acc];
                pend_addr = acc;
                acc++;
            end
            tick();
            guard++;
        end
        host_op_valid = 1'b0;
        for (int k = 0; k < exp_cycles; k++) begin
            core_pc    = 16'(k / stride);
            host_abort = (k == abort_at);
            check("run_core_rst", crst_b, 1'b1);
            check("run_owner", owner_b, 1'b1);
            check("run_ready", ready_b, 1'b0);
            check("run_busy", busy_b, 1'b1);
            check("run_clr_we", clr_we_b, 1'b0);
            if (k == 0) begin
                check("last_we", we_b, 1'b1);
                check("last_addr", addr_b, pend_addr);
                check("last_data", data_b, pend_op);
            end else begin
                check("run_we", we_b, 1'b0);
            end
            tick();
        end
        host_abort = 1'b0;
        check("end_core_rst", crst_b, 1'b0);
        check("end_done", done_b, 1'b1);
        check("end_busy", busy_b, 1'b0);
        check("end_owner", owner_b, 1'b1);
        check("end_status", status_b, exp_status);
        tick();
        check("done_hold", done_b, 1'b1);
    endtask

    int          n, errs, st, cyc, len_r, lim_r, str_r, ab_r;
    int          valid_pat[6] = '{1, 0, 0, 1, 1, 0};
    logic [2:0]  op_pat[6]    = '{3'd3, 3'd5, 3'd6, 3'd1, 3'd2, 3'd0};
    logic        exp_we[6]    = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int          exp_addr[6]  = '{0, 0, 0, 0, 1, 2};
    logic [2:0]  exp_data[6]  = '{3'd0, 3'd3, 3'd0, 3'd0, 3'd1, 3'd2};
    logic [2:0]  ops_a[3]     = '{3'd0, 3'd0, 3'd6};

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // {len, limit, stride, abort_at, status, RUN cycles}; a timeout is taken in the RUN
        // cycle whose counter reads the limit, i.e. once limit RUN cycles have completed.
        tbl[0] = '{3, 0, 1, -1, 1, 4};
        tbl[1] = '{2, 5, 4, -1, 2, 6};
        tbl[2] = '{4, 4, 1, -1, 2, 5};
        tbl[3] = '{1, 0, 2, 1, 3, 2};
        tbl[4] = '{2, 3, 2, 3, 3, 4};
        tbl[5] = '{5, 100, 1, -1, 1, 6};
        tbl[6] = '{3, 100, 1000, -1, 2, 101};

        reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0; host_abort = 1'b0;
        host_op_valid = 1'b0; host_op_data = '0; host_prog_len = '0; step_limit = '0;
        core_pc = '0;
        tick();
        tick();
        reset_n = 1'b1;
        check("rst_core_rst", {crst_a, crst_b}, 2'b00);
        check("rst_owner", {owner_a, owner_b}, 2'b00);
        check("rst_we", {we_a, we_b, clr_we_a, clr_we_b}, 4'b0000);
        check("rst_ready", {ready_a, ready_b}, 2'b00);
        check("rst_busy_done", {busy_a, busy_b, done_a, done_b}, 4'b0000);
        check("rst_status", {status_a, status_b}, 4'b0000);
        check("rst_addr", {addr_a, clr_addr_a, addr_b, clr_addr_b}, 51'd0);

        // dut_a: back-to-back ops 0,0,6, full tape clear, run ends at core_pc=3.
        host_prog_len = 16'd3;
        step_limit    = 32'd0;
        start_a       = 1'b1;
        tick();
        start_a = 1'b0;
        check("a_busy", busy_a, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("a_ready", ready_a, 1'b1);
            check("a_we", we_a, (i > 0));
            if (i > 0) begin
                check("a_addr", addr_a, i - 1);
                check("a_data", data_a, ops_a[i-1]);
            end
            host_op_valid = 1'b1;
            host_op_data  = ops_a[i];
            tick();
        end
        host_op_valid = 1'b0;
        check("a_last_we", {we_a, addr_a, data_a}, {1'b1, 16'd2, 3'd6});
        check("a_ready_drop", ready_a, 1'b0);
        n    = 0;
        errs = 0;
        while (clr_we_a && n < 70000) begin
            if (clr_addr_a != 16'(n) || crst_a || owner_a) errs++;
            n++;
            tick();
        end
        check("a_clear_cycles", n, 65536);
        check("a_clear_errs", errs, 0);
        for (int k = 0; k < 3; k++) begin
            core_pc = (k == 2) ? 16'd3 : 16'd2;
            check("a_run_core_rst", {crst_a, owner_a}, 2'b11);
            tick();
        end
        check("a_end", {done_a, busy_a, crst_a, owner_a, status_a}, {4'b1001, 2'd1});

        // dut_a: abort in the 10th CLEAR cycle.
        core_pc       = '0;
        host_prog_len = 16'd1;
        start_a       = 1'b1;
        tick();
        start_a       = 1'b0;
        host_op_valid = 1'b1;
        host_op_data  = 3'd7;
        tick();
        host_op_valid = 1'b0;
        errs = 0;
        for (int i = 0; i < 9; i++) begin
            if (crst_a || !clr_we_a) errs++;
            tick();
        end
        check("ab_clear_pre", errs, 0);
        check("ab_clr_addr", {clr_we_a, clr_addr_a}, {1'b1, 16'd9});
        host_abort = 1'b1;
        tick();
        host_abort = 1'b0;
        check("ab_end", {done_a, busy_a, clr_we_a, crst_a, status_a}, {4'b1000, 2'd3});
        tick();
        check("ab_hold", {done_a, crst_a}, 2'b10);

        // dut_b: valid pattern 1,0,0,1,1 -> three contiguous writes, none in the gaps.
        host_prog_len = 16'd3;
        step_limit    = 32'd0;
        core_pc       = 16'd3;
        start_b       = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            check("gap_we", we_b, exp_we[c]);
            if (exp_we[c]) begin
                check("gap_addr", addr_b, exp_addr[c]);
                check("gap_data", data_b, exp_data[c]);
            end
            if (we_b) n++;
            host_op_valid = (valid_pat[c] != 0);
            host_op_data  = op_pat[c];
            tick();
        end
        host_op_valid = 1'b0;
        check("gap_writes", n, 3);
        check("gap_end", {done_b, status_b}, {1'b1, 2'd1});

        // dut_b: len=0 goes IDLE -> RUN (1 cycle) -> DONE; start during RUN ignored.
        host_prog_len = 16'd0;
        core_pc       = 16'd0;
        start_b       = 1'b1;
        tick();
        check("z_run", {crst_b, busy_b, ready_b}, 3'b110);
        host_prog_len = 16'd5;
        tick();
        start_b = 1'b0;
        check("z_done", {done_b, busy_b, crst_b, status_b}, {3'b100, 2'd1});
        tick();
        check("z_hold", {done_b, busy_b}, 2'b10);

        // dut_b: reset during RUN abandons the job.
        host_prog_len = 16'd2;
        core_pc       = 16'd0;
        start_b       = 1'b1;
        tick();
        start_b       = 1'b0;
        host_op_valid = 1'b1;
        host_op_data  = 3'd4;
        tick();
        tick();
        host_op_valid = 1'b0;
        tick();
        check("mr_running", crst_b, 1'b1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mr_idle", {crst_b, busy_b, done_b, owner_b, ready_b, we_b, status_b},
              8'b0000_0000);
        check("mr_addr", addr_b, 16'd0);
        tick();
        check("mr_stay", {busy_b, done_b}, 2'b00);

        // Table-driven jobs.
        for (int t = 0; t < 7; t++) begin
            run_job_b(tbl[t].len, tbl[t].lim, tbl[t].stride, tbl[t].abort_at,
                      tbl[t].exp_status, tbl[t].exp_cycles);
        end

        // Randomized jobs checked against the reference.
        for (int r = 0; r < 25; r++) begin
            len_r = $urandom_range(1, 8);
            lim_r = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 30);
            str_r = $urandom_range(1, 4);
            ab_r  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : -1;
            predict(len_r, lim_r, str_r, ab_r, st, cyc);
            run_job_b(len_r, lim_r, str_r, ab_r, st, cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
